// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core. State and flags are registered; strobes are decoded combinationally.
// Latency is 3-5 cycles per instruction with zero-wait memory. FETCH/MEM stall while mem_ready is low, with a bus error after TIMEOUT cycles.
module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] retire_q;
    logic             bus_err_q;
    logic             illegal_q;

    logic       is_reg, is_ld, is_st, is_ctl, is_illegal, use_imm;
    logic [2:0] alu_code;
    logic       wait_last;

    always_comb begin
        is_reg     = 1'b0;
        is_ld      = 1'b0;
        is_st      = 1'b0;
        is_ctl     = 1'b0;
        is_illegal = 1'b0;
        alu_code   = ALU_ADD;
        case (opcode)
            OP_ADD, OP_ADDI: is_reg = 1'b1;
            OP_SUB: begin is_reg = 1'b1; alu_code = ALU_SUB; end
            OP_AND: begin is_reg = 1'b1; alu_code = ALU_AND; end
            OP_OR:  begin is_reg = 1'b1; alu_code = ALU_OR;  end
            OP_XOR: begin is_reg = 1'b1; alu_code = ALU_XOR; end
            OP_LD:  is_ld = 1'b1;
            OP_ST:  is_st = 1'b1;
            OP_BEQ: begin is_ctl = 1'b1; alu_code = ALU_SUB; end
            OP_JMP, OP_NOP, OP_HLT: is_ctl = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

    assign use_imm   = (opcode == OP_ADDI) | is_ld | is_st;
    // An error needs a not-ready cycle; mem_ready on the last allowed cycle still completes.
    assign wait_last = !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_INC;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                alu_op      = alu_code;
                alu_src_imm = use_imm;
                if (is_ctl) begin
                    pc_we = 1'b1;
                    if (opcode == OP_JMP)
                        pc_sel = PC_JMP;
                    else if (opcode == OP_BEQ && alu_zero)
                        pc_sel = PC_BR;
                end
            end
            S_MEM: begin
                mem_req     = 1'b1;
                addr_sel    = 1'b1;
                alu_src_imm = 1'b1;
                mem_we      = is_st;
                pc_we       = mem_ready & is_st;
            end
            S_WB: begin
                reg_we      = 1'b1;
                wb_sel      = is_ld;
                alu_op      = alu_code;
                alu_src_imm = use_imm;
                pc_we       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HALT;
            wait_cnt  <= '0;
            retire_q  <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_HALT: begin
                    if (start) begin
                        state_q   <= S_FETCH;
                        wait_cnt  <= '0;
                        bus_err_q <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state_q <= S_DECODE;
                    end else if (wait_last) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (is_illegal) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_reg) begin
                        state_q <= S_WB;
                    end else if (is_ld || is_st) begin
                        state_q  <= S_MEM;
                        wait_cnt <= '0;
                    end else if (opcode == OP_HLT) begin
                        state_q <= S_HALT;
                    end else if (is_ctl) begin
                        state_q  <= S_FETCH;
                        wait_cnt <= '0;
                    end else begin
                        // IR changed under us after decode; treat as illegal rather than guess.
                        illegal_q <= 1'b1;
                        state_q   <= S_HALT;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_ld) begin
                            state_q <= S_WB;
                        end else begin
                            state_q  <= S_FETCH;
                            wait_cnt <= '0;
                        end
                    end else if (wait_last) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    state_q  <= S_FETCH;
                    wait_cnt <= '0;
                end
                default: state_q <= S_HALT;
            endcase
            // Every pc_we is the last PC update of its instruction.
            if (pc_we)
                retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign bus_err    = bus_err_q;
    assign illegal    = illegal_q;
    assign retire_cnt = retire_q;

endmodule
